// File: rtl/cpu_bus_arbiter_if.sv
// cpu_bus_arbiter_if: CPU, video fetch and video RAM signals of the bus arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// everything around it (CPU wrapper, video timing, RAM).
interface cpu_bus_arbiter_if;
  // CPU side
  logic        cpu_mreq;
  logic        cpu_wr;
  logic [15:0] cpu_a;
  // video fetch side
  logic        vid_req;
  logic [13:0] vid_a;
  logic        vid_ack;
  // CPU clock enables and freeze indication
  logic        cep;
  logic        cen;
  logic        stall;
  // video RAM port
  logic [13:0] ram_a;
  logic        ram_we;
  logic        ram_owner;

  modport master (
    output cpu_mreq, cpu_wr, cpu_a, vid_req, vid_a,
    input  vid_ack, cep, cen, stall, ram_a, ram_we, ram_owner
  );

  modport slave (
    input  cpu_mreq, cpu_wr, cpu_a, vid_req, vid_a,
    output vid_ack, cep, cen, stall, ram_a, ram_we, ram_owner
  );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: generates the Z80 cep/cen enables and shares the video RAM
// bank between CPU memory cycles and the video fetch engine.
// Optional feature macro: VRAM_CONTENTION_EN
//   defined   - video has priority; a CPU hitting video RAM is frozen (stall)
//               and a starvation guard hands the bank to the CPU after MAX_VID
//               consecutive video grants.
//   undefined - the CPU always wins; a CPU video-RAM cycle aborts a running
//               video slot and stall never asserts.
module cpu_bus_arbiter #(
  parameter int         CPU_DIV  = 4,
  parameter int         VID_LEN  = 3,
  parameter int         MAX_VID  = 2,
  parameter logic [1:0] VRAM_SEL = 2'b01
) (
  input logic              clock,
  input logic              reset,
  cpu_bus_arbiter_if.slave bus
);

  localparam logic [3:0] PH_LAST   = 4'(CPU_DIV - 1);
  localparam logic [3:0] PH_MID    = 4'(CPU_DIV / 2 - 1);
  localparam logic [3:0] SLOT_LAST = 4'(VID_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    VID  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  slot_reg, slot_next;
  logic [3:0]  ph_reg, ph_next;

  logic        cvr;
  logic        stall_next;
  logic        cep_next, cen_next;
  logic        ack_next, owner_next, we_next;
  logic [13:0] ram_a_next;

  logic        cep_reg, cen_reg, stall_reg;
  logic        ack_reg, owner_reg, we_reg;
  logic [13:0] ram_a_reg;

`ifdef VRAM_CONTENTION_EN
  localparam int SC_W = (MAX_VID < 1) ? 1 : $clog2(MAX_VID + 1);
  logic [SC_W-1:0] sc_reg, sc_next;
`else
  // The starvation guard has no role when the CPU always wins.
  logic unused_cfg;
  assign unused_cfg = (MAX_VID > 0);
`endif

  // A CPU memory cycle aimed at the video RAM bank.
  assign cvr = !bus.cpu_mreq && (bus.cpu_a[15:14] == VRAM_SEL);

  // State, slot countdown, phase counter and starvation counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      slot_reg  <= '0;
      ph_reg    <= '0;
`ifdef VRAM_CONTENTION_EN
      sc_reg    <= '0;
`endif
    end else begin
      state_reg <= state_next;
      slot_reg  <= slot_next;
      ph_reg    <= ph_next;
`ifdef VRAM_CONTENTION_EN
      sc_reg    <= sc_next;
`endif
    end
  end

  // Next-state logic for the bank owner FSM.
  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
`ifdef VRAM_CONTENTION_EN
    sc_next    = sc_reg;
`endif
    case (state_reg)
      IDLE: begin
`ifdef VRAM_CONTENTION_EN
        // Video wins a tie until it has been granted MAX_VID times in a row
        // over a waiting CPU.
        if (bus.vid_req && (!cvr || (sc_reg < SC_W'(MAX_VID)))) begin
          state_next = VID;
          slot_next  = SLOT_LAST;
          if (cvr) begin
            sc_next = sc_reg + 1'b1;
          end
        end else if (cvr) begin
          state_next = CPU;
          sc_next    = '0;
        end
`else
        if (bus.vid_req && !cvr) begin
          state_next = VID;
          slot_next  = SLOT_LAST;
        end else if (cvr) begin
          state_next = CPU;
        end
`endif
      end
      CPU: begin
        if (!cvr) begin
          state_next = IDLE;
        end
      end
      VID: begin
`ifdef VRAM_CONTENTION_EN
        // A slot always runs to completion, even if vid_req drops.
        if (slot_reg == 4'd0) begin
          state_next = IDLE;
        end else begin
          slot_next = slot_reg - 4'd1;
        end
`else
        // The CPU pre-empts the slot; the video engine simply re-requests.
        if (cvr) begin
          state_next = CPU;
        end else if (slot_reg == 4'd0) begin
          state_next = IDLE;
        end else begin
          slot_next = slot_reg - 4'd1;
        end
`endif
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode and CPU phase sequencing, computed one clock ahead.
  always_comb begin
`ifdef VRAM_CONTENTION_EN
    // The CPU waits whenever it wants the bank and does not hold it yet.
    stall_next = cvr && (state_reg != CPU);
`else
    stall_next = 1'b0;
`endif
    // A frozen CPU sees no enables and keeps its phase.
    cep_next = !stall_next && (ph_reg == PH_LAST);
    cen_next = !stall_next && (ph_reg == PH_MID);
    if (stall_next) begin
      ph_next = ph_reg;
    end else if (ph_reg == PH_LAST) begin
      ph_next = 4'd0;
    end else begin
      ph_next = ph_reg + 4'd1;
    end

    owner_next = (state_next == VID);
    we_next    = (state_next == CPU) && !bus.cpu_wr;
    ack_next   = (state_next == VID) && (slot_next == 4'd0);
    ram_a_next = 14'd0;
    if (state_next == VID) begin
      ram_a_next = bus.vid_a;
    end else if (state_next == CPU) begin
      ram_a_next = bus.cpu_a[13:0];
    end
  end

  // Registered outputs; reset clears them immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cep_reg   <= 1'b0;
      cen_reg   <= 1'b0;
      stall_reg <= 1'b0;
      ack_reg   <= 1'b0;
      owner_reg <= 1'b0;
      we_reg    <= 1'b0;
      ram_a_reg <= '0;
    end else begin
      cep_reg   <= cep_next;
      cen_reg   <= cen_next;
      stall_reg <= stall_next;
      ack_reg   <= ack_next;
      owner_reg <= owner_next;
      we_reg    <= we_next;
      ram_a_reg <= ram_a_next;
    end
  end

  assign bus.cep       = cep_reg;
  assign bus.cen       = cen_reg;
  assign bus.stall     = stall_reg;
  assign bus.vid_ack   = ack_reg;
  assign bus.ram_owner = owner_reg;
  assign bus.ram_we    = we_reg;
  assign bus.ram_a     = ram_a_reg;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb_cpu_bus_arbiter: directed and randomized checks of cpu_bus_arbiter
// against a cycle model kept in the bench. Honours VRAM_CONTENTION_EN.
module tb_cpu_bus_arbiter;
  localparam int         CPU_DIV  = 4;
  localparam int         VID_LEN  = 3;
  localparam int         MAX_VID  = 2;
  localparam logic [1:0] VRAM_SEL = 2'b01;

  localparam int H_NONE = 0;
  localparam int H_CPU  = 1;
  localparam int H_VID  = 2;

  logic clock = 1'b0;
  logic reset;

  cpu_bus_arbiter_if bus ();

  cpu_bus_arbiter #(
    .CPU_DIV (CPU_DIV),
    .VID_LEN (VID_LEN),
    .MAX_VID (MAX_VID),
    .VRAM_SEL(VRAM_SEL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int slots = 0;

  // Reference: who holds the bank, clocks left in the slot, grants in a row
  // over a waiting CPU, and the number of unfrozen clocks since reset.
  typedef struct packed {
    int          holder;
    int          left;
    int          sc;
    int          run;
    logic        cep;
    logic        cen;
    logic        stall;
    logic        ack;
    logic        owner;
    logic        we;
    logic [13:0] a;
  } mdl_t;

  mdl_t mdl;

  function automatic mdl_t step(mdl_t m, logic mreq, logic wr, logic [15:0] a,
                                logic vreq, logic [13:0] va);
    mdl_t n;
    logic cvr;
    logic hold;
    n   = m;
    cvr = !mreq && (a[15:14] == VRAM_SEL);
`ifdef VRAM_CONTENTION_EN
    hold = cvr && (m.holder != H_CPU);
`else
    hold = 1'b0;
`endif
    if (!hold) n.run = m.run + 1;
    n.stall = hold;
    n.cep   = !hold && (n.run % CPU_DIV == 0);
    n.cen   = !hold && (n.run % CPU_DIV == CPU_DIV / 2);
    if (m.holder == H_VID) begin
`ifdef VRAM_CONTENTION_EN
      if (m.left == 1) n.holder = H_NONE;
      else n.left = m.left - 1;
`else
      if (cvr) n.holder = H_CPU;
      else if (m.left == 1) n.holder = H_NONE;
      else n.left = m.left - 1;
`endif
    end else if (m.holder == H_CPU) begin
      if (!cvr) n.holder = H_NONE;
    end else begin
`ifdef VRAM_CONTENTION_EN
      if (vreq && (!cvr || m.sc < MAX_VID)) begin
        n.holder = H_VID;
        n.left   = VID_LEN;
        if (cvr) n.sc = m.sc + 1;
      end else if (cvr) begin
        n.holder = H_CPU;
        n.sc     = 0;
      end
`else
      if (vreq && !cvr) begin
        n.holder = H_VID;
        n.left   = VID_LEN;
      end else if (cvr) begin
        n.holder = H_CPU;
      end
`endif
    end
    n.owner = (n.holder == H_VID);
    n.ack   = (n.holder == H_VID) && (n.left == 1);
    n.we    = (n.holder == H_CPU) && !wr;
    n.a     = (n.holder == H_VID) ? va : (n.holder == H_CPU) ? a[13:0] : 14'h0;
    return n;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) mdl <= '0;
    else mdl <= step(mdl, bus.cpu_mreq, bus.cpu_wr, bus.cpu_a, bus.vid_req, bus.vid_a);
  end

  task automatic cmp1(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    cmp1("m_cep",   32'(bus.cep),       32'(mdl.cep));
    cmp1("m_cen",   32'(bus.cen),       32'(mdl.cen));
    cmp1("m_stall", 32'(bus.stall),     32'(mdl.stall));
    cmp1("m_ack",   32'(bus.vid_ack),   32'(mdl.ack));
    cmp1("m_owner", 32'(bus.ram_owner), 32'(mdl.owner));
    cmp1("m_we",    32'(bus.ram_we),    32'(mdl.we));
    cmp1("m_ram_a", 32'(bus.ram_a),     32'(mdl.a));
  endtask

  // One clock: wait for the inactive edge, then check every output.
  task automatic tick();
    @(negedge clock);
    check_model();
  endtask

  logic [9:0] b_cep, b_cen, b_stall, b_own, b_ack, b_ce;
  logic       ack_seen, stall_seen;

  initial begin
    bus.cpu_mreq = 1'b1;
    bus.cpu_wr   = 1'b1;
    bus.cpu_a    = 16'h0000;
    bus.vid_req  = 1'b0;
    bus.vid_a    = 14'h0;
    reset        = 1'b0;

    // reset state
    repeat (2) tick();
    cmp1("rst_outputs", {bus.ram_owner, bus.ram_we, bus.vid_ack, bus.cep, bus.cen,
                         bus.stall, bus.ram_a}, 32'h0);
    reset = 1'b1;

    // free run: cep on clocks 4 and 8, cen two clocks earlier
    for (int i = 0; i < 8; i++) begin
      tick();
      b_cep[i] = bus.cep; b_cen[i] = bus.cen; b_stall[i] = bus.stall;
    end
    cmp1("free_cep",   32'(b_cep[7:0]),   32'h88);
    cmp1("free_cen",   32'(b_cen[7:0]),   32'h22);
    cmp1("free_stall", 32'(b_stall[7:0]), 32'h00);

    // single video slot
    bus.vid_req = 1'b1;
    bus.vid_a   = 14'h0123;
    for (int i = 0; i < 4; i++) begin
      tick();
      b_own[i] = bus.ram_owner; b_ack[i] = bus.vid_ack;
      if (i == 0) cmp1("slot_addr", 32'(bus.ram_a), 32'h0123);
      if (bus.vid_ack) bus.vid_req = 1'b0;
    end
    cmp1("slot_owner", 32'(b_own[3:0]), 32'h7);
    cmp1("slot_ack",   32'(b_ack[3:0]), 32'h4);

    // non-VRAM CPU cycle alongside back-to-back video slots
    bus.cpu_mreq = 1'b0;
    bus.cpu_a    = 16'h8000;
    bus.vid_req  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      b_cep[i] = bus.cep; b_stall[i] = bus.stall; b_own[i] = bus.ram_owner; b_ack[i] = bus.vid_ack;
    end
    cmp1("nv_cep",   32'(b_cep[7:0]),   32'h88);
    cmp1("nv_stall", 32'(b_stall[7:0]), 32'h00);
    cmp1("nv_owner", 32'(b_own[7:0]),   32'h77);
    cmp1("nv_ack",   32'(b_ack[7:0]),   32'h44);
    bus.vid_req  = 1'b0;
    bus.cpu_mreq = 1'b1;

    // CPU hits video RAM while a slot runs
    bus.vid_req = 1'b1;
    bus.vid_a   = 14'h0123;
    tick();
    bus.cpu_mreq = 1'b0;
    bus.cpu_a    = 16'h4567;
    bus.cpu_wr   = 1'b0;
`ifdef VRAM_CONTENTION_EN
    for (int i = 0; i < 5; i++) begin
      tick();
      b_stall[i] = bus.stall; b_ce[i] = bus.cep | bus.cen;
      if (bus.vid_ack) bus.vid_req = 1'b0;
    end
    cmp1("coll_stall", 32'(b_stall[4:0]), 32'h0F);
    cmp1("coll_no_ce", 32'(b_ce[3:0]),    32'h0);
    cmp1("coll_ram_a", 32'(bus.ram_a),    32'h0567);
    cmp1("coll_we",    32'(bus.ram_we),   32'h1);
    tick();
    tick();
    cmp1("coll_cep_resume", 32'(bus.cep), 32'h1);
    bus.cpu_mreq = 1'b1;
    bus.cpu_wr   = 1'b1;
    repeat (2) tick();

    // starvation guard: two video grants, then the CPU
    bus.vid_req  = 1'b1;
    bus.cpu_mreq = 1'b0;
    bus.cpu_a    = 16'h4567;
    for (int i = 0; i < 10; i++) begin
      tick();
      b_own[i] = bus.ram_owner; b_stall[i] = bus.stall;
      if (i == 8) cmp1("guard_ram_a", 32'(bus.ram_a), 32'h0567);
    end
    cmp1("guard_owner", 32'(b_own),   32'h077);
    cmp1("guard_stall", 32'(b_stall), 32'h1FF);
    bus.vid_req  = 1'b0;
    bus.cpu_mreq = 1'b1;
`else
    tick();
    cmp1("abort_owner", 32'(bus.ram_owner), 32'h0);
    cmp1("abort_ram_a", 32'(bus.ram_a),     32'h0567);
    cmp1("abort_we",    32'(bus.ram_we),    32'h1);
    ack_seen   = bus.vid_ack;
    stall_seen = bus.stall;
    repeat (2) begin
      tick();
      ack_seen   = ack_seen | bus.vid_ack;
      stall_seen = stall_seen | bus.stall;
    end
    cmp1("abort_no_ack",   32'(ack_seen),   32'h0);
    cmp1("abort_no_stall", 32'(stall_seen), 32'h0);
    bus.cpu_mreq = 1'b1;
    bus.cpu_wr   = 1'b1;
    tick();
    tick();
    cmp1("vid_retry", 32'(bus.ram_owner), 32'h1);
    bus.vid_req = 1'b0;
`endif
    repeat (4) tick();

    // reset on clock 2 of a slot
    bus.vid_req = 1'b1;
    bus.vid_a   = 14'h2aaa;
    tick();
    tick();
    bus.vid_req = 1'b0;
    reset       = 1'b0;
    #1;
    cmp1("rst_mid_slot", {bus.ram_owner, bus.ram_we, bus.vid_ack, bus.cep, bus.cen,
                          bus.stall, bus.ram_a}, 32'h0);
    tick();
    reset    = 1'b1;
    ack_seen = 1'b0;
    repeat (6) begin
      tick();
      ack_seen = ack_seen | bus.vid_ack;
    end
    cmp1("rst_no_ack", 32'(ack_seen), 32'h0);

    // randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (bus.vid_ack) begin
        slots++;
        $display("slot %0d done at cycle %0d addr=%h", slots, cyc, bus.ram_a);
      end
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 399) == 0) reset = 1'b0;
      if (bus.vid_req) begin
        if (bus.vid_ack && $urandom_range(0, 3) != 0) bus.vid_req = 1'b0;
        else if ($urandom_range(0, 47) == 0) bus.vid_req = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        bus.vid_req = 1'b1;
        bus.vid_a   = 14'($urandom);
      end
      if ($urandom_range(0, 4) == 0) begin
        bus.cpu_mreq = ($urandom_range(0, 2) == 0);
        bus.cpu_a    = {($urandom_range(0, 1) == 0) ? VRAM_SEL : 2'($urandom), 14'($urandom)};
        bus.cpu_wr   = 1'($urandom_range(0, 1));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
